// File: rtl/t_pulse_debouncer.sv
// Push-button conditioner: two-flop synchroniser, four-state debounce FSM with a
// stable-time counter, and a single-cycle toggle strobe per accepted press.
module t_pulse_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    input  logic       en,
    output logic       t_pulse,
    output logic       btn_level,
    output logic [7:0] press_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARM_HIGH = 2'd1,
        HIGH     = 2'd2,
        ARM_LOW  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             t_pulse_q, t_pulse_d;
    logic             btn_level_q, btn_level_d;
    logic [7:0]       press_cnt_q, press_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            t_pulse_q   <= 1'b0;
            btn_level_q <= 1'b0;
            press_cnt_q <= 8'd0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            t_pulse_q   <= t_pulse_d;
            btn_level_q <= btn_level_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    // Next-state and output logic; only the synchronised sample feeds the FSM.
    always_comb begin
        sync1_d     = btn_in;
        sync2_d     = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        t_pulse_d   = 1'b0;
        btn_level_d = btn_level_q;
        press_cnt_d = press_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = ARM_HIGH;
                    cnt_d   = '0;
                end
            end
            ARM_HIGH: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = HIGH;
                    btn_level_d = 1'b1;
                    t_pulse_d   = en;
                    if (en) begin
                        press_cnt_d = press_cnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (!sync2_q) begin
                    state_d = ARM_LOW;
                    cnt_d   = '0;
                end
            end
            ARM_LOW: begin
                if (sync2_q) begin
                    state_d = HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    btn_level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign t_pulse   = t_pulse_q;
    assign btn_level = btn_level_q;
    assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_t_pulse_debouncer.sv
// Directed bench for t_pulse_debouncer with DEBOUNCE_CYCLES=4; a negedge monitor
// counts pulses, flags back-to-back pulses and models the downstream T flip-flop.
module tb_t_pulse_debouncer;

    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_in;
    logic       en;
    logic       t_pulse;
    logic       btn_level;
    logic [7:0] press_cnt;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   pulses   = 0;
    int   b2b      = 0;
    logic prev_pulse = 1'b0;
    logic tff        = 1'b0;

    t_pulse_debouncer #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .en        (en),
        .t_pulse   (t_pulse),
        .btn_level (btn_level),
        .press_cnt (press_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (t_pulse === 1'b1) begin
            pulses = pulses + 1;
            if (prev_pulse) b2b = b2b + 1;
            tff = ~tff;
        end
        prev_pulse = (t_pulse === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance past the next rising edge; outputs are settled when this returns.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   p0;
        int   b0;
        logic tff0;
        logic pat [5];
        logic gl  [3];

        rst    = 1'b1;
        btn_in = 1'b0;
        en     = 1'b1;
        #2;
        check("rst_t_pulse",   32'(t_pulse),   32'd0);
        check("rst_btn_level", 32'(btn_level), 32'd0);
        check("rst_press_cnt", 32'(press_cnt), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(3);

        // Clean press: E0 is the next edge; pulse sits between E6 and E7.
        p0 = pulses;
        btn_in = 1'b1;
        tick(6);
        check("press_e5_pulse", 32'(t_pulse),   32'd0);
        check("press_e5_level", 32'(btn_level), 32'd0);
        tick(1);
        check("press_e6_pulse", 32'(t_pulse),   32'd1);
        check("press_e6_level", 32'(btn_level), 32'd1);
        check("press_e6_cnt",   32'(press_cnt), 32'd1);
        tick(1);
        check("press_e7_pulse", 32'(t_pulse),   32'd0);
        check("press_e7_level", 32'(btn_level), 32'd1);
        tick(12);
        btn_in = 1'b0;
        tick(6);
        check("release_r5_level", 32'(btn_level), 32'd1);
        tick(1);
        check("release_r6_level", 32'(btn_level), 32'd0);
        check("clean_pulse_total", 32'(pulses - p0), 32'd1);
        tick(4);

        // Press bounce 1,0,1,1,0 is rejected; 10 stable highs are accepted once.
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            btn_in = pat[i];
            tick(1);
        end
        btn_in = 1'b0;
        tick(8);
        check("bounce_level",  32'(btn_level),    32'd0);
        check("bounce_cnt",    32'(press_cnt),    32'd1);
        check("bounce_pulses", 32'(pulses - p0),  32'd0);
        btn_in = 1'b1;
        tick(10);
        check("after_bounce_pulses", 32'(pulses - p0), 32'd1);
        check("after_bounce_level",  32'(btn_level),   32'd1);
        check("after_bounce_cnt",    32'(press_cnt),   32'd2);

        // Release bounce 0,1,0 from HIGH, then held high: no pulse, level stays.
        gl = '{1'b0, 1'b1, 1'b0};
        p0 = pulses;
        for (int i = 0; i < 3; i++) begin
            btn_in = gl[i];
            tick(1);
        end
        btn_in = 1'b1;
        tick(10);
        check("rel_bounce_level",  32'(btn_level),   32'd1);
        check("rel_bounce_pulses", 32'(pulses - p0), 32'd0);
        check("rel_bounce_cnt",    32'(press_cnt),   32'd2);
        btn_in = 1'b0;
        tick(6);
        check("rel2_r5_level", 32'(btn_level), 32'd1);
        tick(1);
        check("rel2_r6_level", 32'(btn_level), 32'd0);
        check("rel2_pulses",   32'(pulses - p0), 32'd0);
        tick(4);

        // Enable gating: level rises without a pulse; raising en in HIGH is too late.
        en = 1'b0;
        p0 = pulses;
        btn_in = 1'b1;
        tick(7);
        check("en0_level", 32'(btn_level), 32'd1);
        check("en0_pulse", 32'(t_pulse),   32'd0);
        check("en0_cnt",   32'(press_cnt), 32'd2);
        en = 1'b1;
        tick(5);
        check("en0_late_pulses", 32'(pulses - p0), 32'd0);
        btn_in = 1'b0;
        tick(10);
        check("en0_release_level", 32'(btn_level), 32'd0);
        btn_in = 1'b1;
        tick(7);
        check("en1_pulse", 32'(t_pulse),   32'd1);
        check("en1_cnt",   32'(press_cnt), 32'd3);
        en = 1'b0;
        tick(1);
        check("en1_pulse_fall", 32'(t_pulse), 32'd0);
        btn_in = 1'b0;
        tick(10);
        en = 1'b1;

        // Counter wrap: 256 clean presses from a fresh reset.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("wrap_start_cnt", 32'(press_cnt), 32'd0);
        tff0 = tff;
        p0   = pulses;
        b0   = b2b;
        for (int i = 0; i < 256; i++) begin
            btn_in = 1'b1;
            tick(12);
            btn_in = 1'b0;
            tick(12);
            if (i == 254) check("wrap_cnt_255", 32'(press_cnt), 32'd255);
        end
        check("wrap_cnt_0",   32'(press_cnt),   32'd0);
        check("wrap_pulses",  32'(pulses - p0), 32'd256);
        check("wrap_no_b2b",  32'(b2b - b0),    32'd0);
        check("wrap_tff",     32'(tff),         32'(tff0));

        // Async reset while in ARM_HIGH, button still held afterwards.
        btn_in = 1'b1;
        tick(8);
        check("pre_rst_cnt", 32'(press_cnt), 32'd1);
        btn_in = 1'b0;
        tick(10);
        btn_in = 1'b1;
        tick(4);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_cnt",   32'(press_cnt), 32'd0);
        check("async_rst_level", 32'(btn_level), 32'd0);
        check("async_rst_pulse", 32'(t_pulse),   32'd0);
        tick(1);
        rst = 1'b0;
        // E0 is the first edge after reset release.
        tick(6);
        check("post_rst_e5_pulse", 32'(t_pulse), 32'd0);
        tick(1);
        check("post_rst_e6_pulse", 32'(t_pulse),   32'd1);
        check("post_rst_e6_cnt",   32'(press_cnt), 32'd1);
        tick(1);
        check("post_rst_e7_pulse", 32'(t_pulse), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
